hazard_forward_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined datapath, replacing the fixed two-operand, four-register combinational forwarding logic. It keeps its own shadow of the destination/source tags in the EX, MEM and WB stages and produces per-operand forward selects. It also detects load-use hazards and inserts a one-cycle bubble, freezes the pipe while a load waits on memory, and honours a branch flush. Sits beside the ID/EX, EX/MEM and MEM/WB registers and drives their enables and the EX operand muxes.

---
 rtl/hazard_forward_ctrl_pkg.sv | 29 ++
 rtl/hazard_forward_ctrl_fwd_mux_sel.sv | 28 ++
 rtl/hazard_forward_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_forward_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller:
// forward-select encodings, wait FSM state type and the per-stage tag record.
package hazard_forward_ctrl_pkg;

    // Tag dst field is sized for the widest register file we expect to build.
    localparam int DST_W = 8;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [DST_W-1:0] dst;
        logic             wr;
        logic             load;
    } stage_tag_t;

    // Register 0 is hard-wired zero, so it never has a producer.
    function automatic logic writer_matches(input stage_tag_t t, input logic [DST_W-1:0] r);
        return t.valid && t.wr && (t.dst == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_mux_sel.sv
// Per-operand forward select: youngest non-load producer in MEM first, then WB,
// otherwise the register file.
module hazard_forward_ctrl_fwd_mux_sel
    import hazard_forward_ctrl_pkg::*;
(
    input  logic [DST_W-1:0] src,
    input  logic             used,
    input  stage_tag_t       mem_tag,
    input  stage_tag_t       wb_tag,
    output logic [1:0]       sel
);

    logic unused_wb_load;
    assign unused_wb_load = wb_tag.load;

    always_comb begin
        sel = FWD_REG;
        if (used) begin
            // A load in MEM has no data yet; it is picked up from WB a cycle later.
            if (writer_matches(mem_tag, src) && !mem_tag.load) begin
                sel = FWD_MEM;
            end else if (writer_matches(wb_tag, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: shadows EX/MEM/WB tags, drives operand
// forward selects, load-use bubbles, memory-wait freeze and a stall counter.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter  int NUM_REGS = 4,
    parameter  int NUM_SRC  = 2,
    parameter  int CNT_W    = 16,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [NUM_SRC*RW-1:0] id_src,
    input  logic [NUM_SRC-1:0]    id_src_used,
    input  logic [RW-1:0]         id_dst,
    input  logic                  id_wr,
    input  logic                  id_load,
    input  logic                  mem_ready,
    input  logic                  flush,
    output logic [NUM_SRC*2-1:0]  fwd_sel,
    output logic                  stall_id,
    output logic                  freeze,
    output logic [CNT_W-1:0]      stall_cycles
);

    stage_tag_t            ex_tag_q, ex_tag_d;
    stage_tag_t            mem_tag_q, mem_tag_d;
    stage_tag_t            wb_tag_q, wb_tag_d;
    logic [NUM_SRC*RW-1:0] ex_src_q, ex_src_d;
    logic [NUM_SRC-1:0]    ex_used_q, ex_used_d;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;

    logic [NUM_SRC-1:0]    lu_hit;
    logic                  lu;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            hazard_forward_ctrl_fwd_mux_sel u_sel (
                .src     (DST_W'(ex_src_q[gi*RW +: RW])),
                .used    (ex_used_q[gi]),
                .mem_tag (mem_tag_q),
                .wb_tag  (wb_tag_q),
                .sel     (fwd_sel[gi*2 +: 2])
            );

            assign lu_hit[gi] = id_src_used[gi] &&
                                writer_matches(ex_tag_q, DST_W'(id_src[gi*RW +: RW]));
        end
    endgenerate

    always_comb begin
        // While waiting, MEM is held, so only mem_ready can end the wait.
        if (state_q == MEM_WAIT) begin
            freeze = !mem_ready;
        end else begin
            freeze = mem_tag_q.valid && mem_tag_q.load && !mem_ready;
        end
        state_d = freeze ? MEM_WAIT : RUN;

        lu       = id_valid && ex_tag_q.load && (|lu_hit) && !flush;
        stall_id = lu && !freeze;

        ex_tag_d       = ex_tag_q;
        mem_tag_d      = mem_tag_q;
        wb_tag_d       = wb_tag_q;
        ex_src_d       = ex_src_q;
        ex_used_d      = ex_used_q;
        if (!freeze) begin
            ex_tag_d.valid = id_valid && !flush && !lu;
            ex_tag_d.dst   = DST_W'(id_dst);
            ex_tag_d.wr    = id_wr;
            ex_tag_d.load  = id_load;
            ex_src_d       = id_src;
            ex_used_d      = id_src_used;
            mem_tag_d      = ex_tag_q;
            wb_tag_d       = mem_tag_q;
        end

        stall_cycles_d = stall_cycles_q;
        if ((stall_id || freeze) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag_q       <= '0;
            mem_tag_q      <= '0;
            wb_tag_q       <= '0;
            ex_src_q       <= '0;
            ex_used_q      <= '0;
            state_q        <= RUN;
            stall_cycles_q <= '0;
        end else begin
            ex_tag_q       <= ex_tag_d;
            mem_tag_q      <= mem_tag_d;
            wb_tag_q       <= wb_tag_d;
            ex_src_q       <= ex_src_d;
            ex_used_q      <= ex_used_d;
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scenarios for hazard_forward_ctrl with hand-derived expectations.
module tb_hazard_forward_ctrl;
    import hazard_forward_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src;
    logic [1:0]  id_src_used;
    logic [1:0]  id_dst;
    logic        id_wr;
    logic        id_load;
    logic        mem_ready;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall_id;
    logic        freeze;
    logic [15:0] stall_cycles;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int exp_cnt = 0;

    hazard_forward_ctrl #(.NUM_REGS(4), .NUM_SRC(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .id_dst       (id_dst),
        .id_wr        (id_wr),
        .id_load      (id_load),
        .mem_ready    (mem_ready),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall_id     (stall_id),
        .freeze       (freeze),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [1:0] s1, input logic [1:0] s0,
                          input logic [1:0] used, input logic [1:0] dst,
                          input logic wr, input logic ld);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dst      = dst;
        id_wr       = wr;
        id_load     = ld;
        #1;
    endtask

    task automatic idle;
        set_id(1'b0, 2'd0, 2'd0, 2'b00, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic tick;
        $display("cycle %0d id_v=%b src=%h used=%b flush=%b mrdy=%b fwd_sel=%b stall_id=%b freeze=%b cnt=%0d",
                 cyc, id_valid, id_src, id_src_used, flush, mem_ready, fwd_sel, stall_id, freeze, stall_cycles);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_ready = 1'b1;
        flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd_sel: got %b want 0000", fwd_sel); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall_id: got %b want 0", stall_id); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b want 0", freeze); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_back_to_back;
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd1, 1'b1, 1'b0); tick();
        set_id(1'b1, 2'd1, 2'd1, 2'b11, 2'd0, 1'b0, 1'b0); tick();
        set_id(1'b1, 2'd0, 2'd1, 2'b01, 2'd0, 1'b0, 1'b0);
        checks++; if (fwd_sel !== 4'b1010) begin errors++; $display("FAIL alu_both_mem: got %b want 1010", fwd_sel); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL alu_no_stall: got %b want 0", stall_id); end
        tick();
        idle();
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL alu_next_wb: got %b want 0001", fwd_sel); end
        repeat (3) tick();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd1, 1'b1, 1'b0); tick();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd1, 1'b1, 1'b0); tick();
        set_id(1'b1, 2'd1, 2'd0, 2'b10, 2'd0, 1'b0, 1'b0); tick();
        idle();
        checks++; if (fwd_sel !== 4'b1000) begin errors++; $display("FAIL alu_youngest: got %b want 1000", fwd_sel); end
        repeat (3) tick();
    endtask

    task automatic test_r0;
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd0, 1'b1, 1'b0); tick();
        set_id(1'b1, 2'd0, 2'd0, 2'b11, 2'd0, 1'b0, 1'b0); tick();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd0, 1'b1, 1'b1);
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL r0_no_fwd: got %b want 0000", fwd_sel); end
        tick();
        set_id(1'b1, 2'd0, 2'd0, 2'b11, 2'd0, 1'b0, 1'b0);
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL r0_load_no_stall: got %b want 0", stall_id); end
        checks++; if (stall_cycles !== 16'(exp_cnt)) begin errors++; $display("FAIL r0_cnt: got %0d want %0d", stall_cycles, exp_cnt); end
        tick();
        idle();
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL r0_after_load: got %b want 0000", fwd_sel); end
        repeat (3) tick();
    endtask

    task automatic test_load_use;
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd2, 1'b1, 1'b1); tick();
        set_id(1'b1, 2'd3, 2'd2, 2'b01, 2'd1, 1'b1, 1'b0);
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall_id); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL lu_no_freeze: got %b want 0", freeze); end
        exp_cnt++;
        tick();
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lu_one_bubble: got %b want 0", stall_id); end
        checks++; if (stall_cycles !== 16'(exp_cnt)) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cycles, exp_cnt); end
        tick();
        idle();
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL lu_consumer_wb: got %b want 0001", fwd_sel); end
        repeat (3) tick();
    endtask

    task automatic test_mem_wait;
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd3, 1'b1, 1'b1); tick();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd1, 1'b1, 1'b0); tick();
        mem_ready = 1'b0;
        set_id(1'b1, 2'd0, 2'd3, 2'b01, 2'd0, 1'b0, 1'b0);
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL wait_freeze1: got %b want 1", freeze); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL wait_no_stall: got %b want 0", stall_id); end
        exp_cnt++;
        tick();
        checks++; if (dut.state_q !== MEM_WAIT) begin errors++; $display("FAIL wait_state: got %0d want %0d", dut.state_q, MEM_WAIT); end
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL wait_freeze2: got %b want 1", freeze); end
        exp_cnt++;
        tick();
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL wait_freeze3: got %b want 1", freeze); end
        exp_cnt++;
        tick();
        mem_ready = 1'b1;
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL wait_release: got %b want 0", freeze); end
        checks++; if (stall_cycles !== 16'(exp_cnt)) begin errors++; $display("FAIL wait_cnt: got %0d want %0d", stall_cycles, exp_cnt); end
        tick();
        idle();
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL wait_back_run: got %0d want %0d", dut.state_q, RUN); end
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL wait_held_fwd: got %b want 0001", fwd_sel); end
        repeat (3) tick();
    endtask

    task automatic test_flush_lu;
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd2, 1'b1, 1'b1); tick();
        flush = 1'b1;
        set_id(1'b1, 2'd0, 2'd2, 2'b01, 2'd0, 1'b0, 1'b0);
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL flush_no_stall: got %b want 0", stall_id); end
        tick();
        flush = 1'b0;
        set_id(1'b1, 2'd0, 2'd2, 2'b01, 2'd0, 1'b0, 1'b0);
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL flush_ex_bubble: got %b want 0", stall_id); end
        checks++; if (stall_cycles !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cycles, exp_cnt); end
        tick();
        idle();
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL flush_refetch_wb: got %b want 0001", fwd_sel); end
        repeat (3) tick();
    endtask

    task automatic test_reset_in_wait;
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd2, 1'b1, 1'b0); tick();
        set_id(1'b1, 2'd0, 2'd0, 2'b00, 2'd1, 1'b1, 1'b1); tick();
        set_id(1'b1, 2'd0, 2'd2, 2'b01, 2'd0, 1'b0, 1'b0); tick();
        mem_ready = 1'b0;
        idle();
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL rstw_freeze: got %b want 1", freeze); end
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL rstw_fwd: got %b want 0001", fwd_sel); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rstw_freeze_drop: got %b want 0", freeze); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rstw_stall_drop: got %b want 0", stall_id); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL rstw_fwd_drop: got %b want 0000", fwd_sel); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rstw_cnt: got %0d want 0", stall_cycles); end
        exp_cnt = 0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL rstw_stays_run: got %0d want %0d", dut.state_q, RUN); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rstw_no_freeze: got %b want 0", freeze); end
        mem_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_r0();
        test_load_use();
        test_mem_wait();
        test_flush_lu();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
